// File: rtl/sub_stream.sv
// sub_stream: elastic DEPTH-entry FIFO with a per-word transform on push.
// Define SUB_STREAM_STATS_EN to add the accepted_count/stall_count counters.
module sub_stream #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [LW-1:0]    level,
  output logic             overflow
`ifdef SUB_STREAM_STATS_EN
  ,
  output logic [31:0]      accepted_count,
  output logic [31:0]      stall_count
`endif
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr, r_rd, w_rd_nxt;
  logic [LW-1:0]    r_level;
  logic [WIDTH-1:0] r_out, w_xf;
  logic             r_ovf, w_push, w_pop;
  assign in_ready  = r_level != LW'(DEPTH);
  assign out_valid = r_level != '0;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign out_data  = r_out;
  assign level     = r_level;
  assign overflow  = r_ovf;
  always_comb begin
    w_xf = mode == 2'd0 ? in_data :
           mode == 2'd1 ? ~in_data :
           mode == 2'd2 ? in_data + WIDTH'(1) :
                          {in_data[WIDTH-2:0], in_data[WIDTH-1]};
    w_rd_nxt = w_pop ? r_rd + AW'(1) : r_rd;
  end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= w_xf;
  // Output register preloads the next head; a word written into the slot becoming head bypasses memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
      r_out   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      r_rd    <= w_rd_nxt;
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
      r_out   <= (w_push && r_wr == w_rd_nxt) ? w_xf : r_mem[w_rd_nxt];
      if (in_valid && !in_ready) r_ovf <= 1'b1;
    end
  end
`ifdef SUB_STREAM_STATS_EN
  logic [31:0] r_acc, r_stall;
  assign accepted_count = r_acc;
  assign stall_count    = r_stall;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc   <= '0;
      r_stall <= '0;
    end else begin
      if (w_push && r_acc != '1) r_acc <= r_acc + 32'd1;
      if (out_valid && !out_ready && r_stall != '1) r_stall <= r_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_sub_stream.sv
// tb_sub_stream: vector table plus scoreboarded multi-cycle sequences for sub_stream.
module tb_sub_stream;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [2:0]  level;
  logic        overflow;
  logic [31:0] exp_d = '0;
`ifdef SUB_STREAM_STATS_EN
  logic [31:0] accepted_count, stall_count;
`endif
  int tests = 0;
  int fails = 0;
  int npop = 0;
  int base;
  logic [31:0] q[$];

  sub_stream #(.WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .overflow(overflow)
`ifdef SUB_STREAM_STATS_EN
    , .accepted_count(accepted_count), .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  m;
    logic [31:0] d;
    logic [31:0] e;
  } vec_t;
  vec_t vt[8];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [31:0] d, input logic [31:0] e, input logic r);
    in_valid = v; mode = m; in_data = d; exp_d = e; out_ready = r;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    drive(0, 0, 0, 0, 0);
    reset = 1'b1;
    tick();
    q.delete();
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        npop++;
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_unexpected: got %h expected none", out_data);
        end else chk("sb_data", out_data, q.pop_front());
      end
      if (in_valid && in_ready) q.push_back(exp_d);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vt[1] = '{2'd1, 32'hFFFF_FFFF, 32'h0000_0000};
    vt[2] = '{2'd2, 32'hFFFF_FFFF, 32'h0000_0000};
    vt[3] = '{2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vt[4] = '{2'd0, 32'h1234_5678, 32'h1234_5678};
    vt[5] = '{2'd1, 32'hA5A5_A5A5, 32'h5A5A_5A5A};
    vt[6] = '{2'd2, 32'h7FFF_FFFF, 32'h8000_0000};
    vt[7] = '{2'd3, 32'h8000_0001, 32'h0000_0003};
    tick();
    do_reset();
    tick();
    chk("rst_level", 32'(level), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_out_data", out_data, 0);

    for (int i = 0; i < 8; i++) begin
      drive(1, vt[i].m, vt[i].d, vt[i].e, 1);
      tick();
      drive(0, 0, 0, 0, 1);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 1);
      chk($sformatf("vec%0d_data", i), out_data, vt[i].e);
      tick();
    end
    chk("vec_drained", 32'(q.size()), 0);

    do_reset();
    base = npop;
    for (int k = 1; k <= 5; k++) begin
      drive(1, 0, 32'(k), 32'(k), 0);
      tick();
      if (k >= 2) chk($sformatf("ovf_hold%0d", k), out_data, 1);
      if (k == 4) begin
        chk("full_in_ready", 32'(in_ready), 0);
        chk("full_level", 32'(level), 4);
        chk("full_no_ovf", 32'(overflow), 0);
      end
    end
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_level", 32'(level), 4);
    drive(0, 0, 0, 0, 1);
    repeat (6) tick();
    chk("ovf_pops", 32'(npop - base), 4);
    chk("ovf_empty", 32'(level), 0);
    chk("ovf_sticky", 32'(overflow), 1);

    do_reset();
    base = npop;
    drive(1, 0, 32'hE0, 32'hE0, 0);
    tick();
    drive(1, 0, 32'hE1, 32'hE1, 0);
    tick();
    chk("pp_level_pre", 32'(level), 2);
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 32'h10 + 32'(i), 32'h10 + 32'(i), 1);
      tick();
      chk($sformatf("pp_level%0d", i), 32'(level), 2);
    end
    drive(0, 0, 0, 0, 1);
    repeat (4) tick();
    chk("pp_pops", 32'(npop - base), 12);
    chk("pp_empty", 32'(q.size()), 0);

    do_reset();
    for (int k = 1; k <= 5; k++) begin
      drive(1, 0, 32'(k), 32'(k), 0);
      tick();
    end
    drive(0, 0, 0, 0, 1);
    tick();
    chk("mid_level3", 32'(level), 3);
    chk("mid_ovf", 32'(overflow), 1);
    do_reset();
    chk("mid_rst_level", 32'(level), 0);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_ovf", 32'(overflow), 0);
    drive(1, 0, 32'hA5, 32'hA5, 1);
    tick();
    drive(0, 0, 0, 0, 1);
    chk("a5_valid", 32'(out_valid), 1);
    chk("a5_data", out_data, 32'hA5);
    tick();
    chk("a5_drained", 32'(q.size()), 0);

`ifdef SUB_STREAM_STATS_EN
    do_reset();
    chk("st_acc_rst", accepted_count, 0);
    chk("st_stall_rst", stall_count, 0);
    for (int k = 0; k < 6; k++) begin
      drive(1, 0, 32'h40 + 32'(k), 32'h40 + 32'(k), 1);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    repeat (3) tick();
    drive(0, 0, 0, 0, 1);
    tick();
    chk("st_accepted", accepted_count, 6);
    chk("st_stall", stall_count, 3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
